// File: rtl/traffic_mode_if.sv
// Bundle between the request/sensor side and the mode scheduler.
// master drives requests, slave (the scheduler) drives interrupts.
interface traffic_mode_if;
    logic [1:0] vip_req;
    logic       night_en;
    logic [3:0] prev_counter;
    logic       isvip;
    logic       vip_path_index;
    logic       isnight;
    logic       night_path_index;
    logic [3:0] rollback_cnt;
    logic       vip_timeout;
    logic       busy;

    modport master (
        output vip_req, night_en, prev_counter,
        input  isvip, vip_path_index, isnight, night_path_index,
        input  rollback_cnt, vip_timeout, busy
    );

    modport slave (
        input  vip_req, night_en, prev_counter,
        output isvip, vip_path_index, isnight, night_path_index,
        output rollback_cnt, vip_timeout, busy
    );
endinterface

// File: rtl/traffic_mode_scheduler.sv
// Sequences VIP / night interrupts for one intersection controller.
// Round-robin VIP grant, min/max hold, guard gap, prev_counter capture.
module traffic_mode_scheduler #(
    parameter int VIP_MIN    = 8,
    parameter int VIP_MAX    = 60,
    parameter int GAP_CYC    = 4,
    parameter int CAP_DLY    = 2,
    parameter bit NIGHT_PATH = 1'b0
) (
    input logic           clk,
    input logic           start,
    traffic_mode_if.slave tm
);
    localparam int CW = $clog2(VIP_MAX + 1);
    localparam int GW = $clog2(GAP_CYC);

    typedef enum logic [1:0] {IDLE, NIGHT, VIP, GAP} state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] vip_cnt_q, vip_cnt_d, vip_cnt_nx;
    logic [GW-1:0] gap_cnt_q, gap_cnt_d;
    logic          last_grant_q, last_grant_d;
    logic [1:0]    lockout_q, lockout_d;
    logic          isvip_q, isvip_d;
    logic          isnight_q, isnight_d;
    logic          path_q, path_d;
    logic [3:0]    rollback_q, rollback_d;
    logic          vip_to_q, vip_to_d;
    logic          busy_q, busy_d;
    logic [1:0]    eff_req;
    logic          grant;
    logic          vip_done;
    logic          vip_max;

    assign eff_req    = tm.vip_req & ~lockout_q;
    // Single requester wins outright; a tie goes to the path not served last.
    assign grant      = (eff_req == 2'b11) ? ~last_grant_q : eff_req[1];
    assign vip_cnt_nx = vip_cnt_q + CW'(1);
    assign vip_done   = (vip_cnt_nx >= CW'(VIP_MIN)) && !tm.vip_req[path_q];
    assign vip_max    = (vip_cnt_nx == CW'(VIP_MAX));

    // Next-state and registered-output values for every state.
    always_comb begin
        state_d      = state_q;
        vip_cnt_d    = vip_cnt_q;
        gap_cnt_d    = gap_cnt_q;
        last_grant_d = last_grant_q;
        lockout_d    = lockout_q & tm.vip_req;
        isvip_d      = 1'b0;
        isnight_d    = 1'b0;
        path_d       = path_q;
        rollback_d   = rollback_q;
        vip_to_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (|eff_req) begin
                    state_d      = VIP;
                    isvip_d      = 1'b1;
                    path_d       = grant;
                    last_grant_d = grant;
                    vip_cnt_d    = '0;
                end else if (tm.night_en) begin
                    state_d   = NIGHT;
                    isnight_d = 1'b1;
                end
            end
            NIGHT: begin
                isnight_d = 1'b1;
                if (|eff_req) begin
                    state_d      = VIP;
                    isnight_d    = 1'b0;
                    isvip_d      = 1'b1;
                    path_d       = grant;
                    last_grant_d = grant;
                    vip_cnt_d    = '0;
                end else if (!tm.night_en) begin
                    state_d   = GAP;
                    isnight_d = 1'b0;
                    gap_cnt_d = '0;
                end
            end
            VIP: begin
                if (vip_cnt_q == CW'(CAP_DLY)) rollback_d = tm.prev_counter;
                if (vip_done) begin
                    state_d   = GAP;
                    gap_cnt_d = '0;
                end else if (vip_max) begin
                    state_d           = GAP;
                    gap_cnt_d         = '0;
                    vip_to_d          = 1'b1;
                    lockout_d[path_q] = 1'b1;
                end else begin
                    isvip_d   = 1'b1;
                    vip_cnt_d = (vip_cnt_q == CW'(VIP_MAX)) ? vip_cnt_q
                                                            : vip_cnt_nx;
                end
            end
            GAP: begin
                if (gap_cnt_q == GW'(GAP_CYC - 1)) state_d = IDLE;
                else gap_cnt_d = gap_cnt_q + GW'(1);
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State and output registers; reset drops every interrupt at once.
    always_ff @(posedge clk or negedge start) begin
        if (!start) begin
            state_q      <= IDLE;
            vip_cnt_q    <= '0;
            gap_cnt_q    <= '0;
            last_grant_q <= 1'b1;
            lockout_q    <= 2'b00;
            isvip_q      <= 1'b0;
            isnight_q    <= 1'b0;
            path_q       <= 1'b0;
            rollback_q   <= 4'd0;
            vip_to_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            vip_cnt_q    <= vip_cnt_d;
            gap_cnt_q    <= gap_cnt_d;
            last_grant_q <= last_grant_d;
            lockout_q    <= lockout_d;
            isvip_q      <= isvip_d;
            isnight_q    <= isnight_d;
            path_q       <= path_d;
            rollback_q   <= rollback_d;
            vip_to_q     <= vip_to_d;
            busy_q       <= busy_d;
        end
    end

    assign tm.isvip            = isvip_q;
    assign tm.isnight          = isnight_q;
    assign tm.vip_path_index   = path_q;
    assign tm.night_path_index = NIGHT_PATH;
    assign tm.rollback_cnt     = rollback_q;
    assign tm.vip_timeout      = vip_to_q;
    assign tm.busy             = busy_q;
endmodule

// File: tb/tb_traffic_mode_scheduler.sv
// Bench for traffic_mode_scheduler: directed scenarios plus random
// traffic, all compared against a session-level reference model.
module tb_traffic_mode_scheduler;
    localparam int VIP_MIN = 8;
    localparam int VIP_MAX = 60;
    localparam int GAP_CYC = 4;
    localparam int CAP_DLY = 2;

    logic clk;
    logic start;
    traffic_mode_if tm();

    traffic_mode_scheduler dut (
        .clk   (clk),
        .start (start),
        .tm    (tm)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;
    int hi_cnt = 0;
    int to_cnt = 0;

    // Reference model: age of the running VIP session (-1 = none),
    // remaining guard cycles, night flag, served path, lockouts.
    int       m_age;
    int       m_gap;
    bit       m_night;
    bit       m_path;
    bit       m_last;
    bit       m_to;
    bit [1:0] m_lock;
    bit [3:0] m_rb;

    function automatic void model_reset();
        m_age = -1; m_gap = 0; m_night = 0; m_path = 0;
        m_last = 1; m_to = 0; m_lock = 2'b00; m_rb = 4'd0;
    endfunction

    function automatic void model_step(input bit [1:0] req, input bit nen,
                                       input bit [3:0] pc);
        bit [1:0] eff;
        bit       set_lock;
        int       g;
        eff = req & ~m_lock;
        m_to = 0;
        set_lock = 0;
        if (m_age >= 0) begin
            if (m_age == CAP_DLY) m_rb = pc;
            if (m_age + 1 >= VIP_MIN && !req[m_path]) begin
                m_age = -1; m_gap = GAP_CYC;
            end else if (m_age + 1 == VIP_MAX) begin
                m_age = -1; m_gap = GAP_CYC; m_to = 1; set_lock = 1;
            end else begin
                m_age++;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else if (eff != 0) begin
            g = -1;
            for (int k = 1; k <= 2; k++) begin
                if (g < 0 && eff[(int'(m_last) + k) % 2]) g = (int'(m_last) + k) % 2;
            end
            m_path = g[0];
            m_last = g[0];
            m_age = 0;
            m_night = 0;
        end else if (m_night) begin
            if (!nen) begin m_night = 0; m_gap = GAP_CYC; end
        end else begin
            m_night = nen;
        end
        m_lock = m_lock & req;
        if (set_lock) m_lock[m_path] = 1'b1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_outs(input string ph);
        bit busy_e;
        busy_e = (m_age >= 0) || (m_gap > 0) || m_night;
        chk({ph, ".isvip"},   32'(tm.isvip),          32'(m_age >= 0));
        chk({ph, ".isnight"}, 32'(tm.isnight),        32'(m_night));
        chk({ph, ".path"},    32'(tm.vip_path_index), 32'(m_path));
        chk({ph, ".npath"},   32'(tm.night_path_index), 32'(0));
        chk({ph, ".rb"},      32'(tm.rollback_cnt),   32'(m_rb));
        chk({ph, ".tmo"},     32'(tm.vip_timeout),    32'(m_to));
        chk({ph, ".busy"},    32'(tm.busy),           32'(busy_e));
    endtask

    task automatic step(input logic [1:0] req, input logic nen,
                        input logic [3:0] pc, input string ph);
        tm.vip_req = req;
        tm.night_en = nen;
        tm.prev_counter = pc;
        @(posedge clk);
        model_step(req, nen, pc);
        @(negedge clk);
        check_outs(ph);
        if (tm.isvip === 1'b1) hi_cnt++;
        if (tm.vip_timeout === 1'b1) to_cnt++;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] r;
        logic       n;
        int         lows;
        logic [0:2] exp_g;
        start = 1'b0;
        tm.vip_req = 2'b00;
        tm.night_en = 1'b0;
        tm.prev_counter = 4'd0;
        model_reset();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_outs("reset");
        start = 1'b1;

        // Ties alternate starting from path 0.
        exp_g = 3'b010;
        for (int s = 0; s < 3; s++) begin
            for (int i = 0; i < 20 && m_age < 0; i++) step(2'b11, 0, 4'd5, "t2");
            chk("t2.granted", 32'(tm.isvip), 32'(1));
            chk("t2.grant", 32'(tm.vip_path_index), 32'(exp_g[s]));
            for (int i = 0; i < 20 && m_age >= 0; i++) step(2'b00, 0, 4'd5, "t2");
            repeat (6) step(2'b00, 0, 4'd5, "t2");
        end

        // 20-cycle request gives exactly 20 cycles of isvip.
        hi_cnt = 0;
        repeat (20) step(2'b01, 0, 4'd3, "t1");
        repeat (10) step(2'b00, 0, 4'd9, "t1");
        chk("t1.hi_cnt", 32'(hi_cnt), 32'(20));
        chk("t1.rb", 32'(tm.rollback_cnt), 32'(3));

        // Short request is still held for the minimum time.
        hi_cnt = 0;
        repeat (2) step(2'b01, 0, 4'd7, "t4");
        repeat (14) step(2'b00, 0, 4'd7, "t4");
        chk("t4.hi_cnt", 32'(hi_cnt), 32'(VIP_MIN));

        // Held request times out and is locked out until it drops.
        hi_cnt = 0;
        to_cnt = 0;
        repeat (75) step(2'b10, 0, 4'd12, "t3");
        chk("t3.hi_cnt", 32'(hi_cnt), 32'(VIP_MAX));
        chk("t3.to_cnt", 32'(to_cnt), 32'(1));
        repeat (20) step(2'b10, 0, 4'd12, "t3");
        chk("t3.locked", 32'(hi_cnt), 32'(VIP_MAX));
        step(2'b00, 0, 4'd12, "t3");
        repeat (10) step(2'b10, 0, 4'd12, "t3");
        chk("t3.regrant", 32'(hi_cnt > VIP_MAX), 32'(1));
        for (int i = 0; i < 80 && (m_age >= 0 || m_gap > 0); i++)
            step(2'b00, 0, 4'd0, "t3");

        // Night preempted by VIP, then night resumes after the gap.
        repeat (4) step(2'b00, 1, 4'd6, "t5");
        chk("t5.night", 32'(tm.isnight), 32'(1));
        step(2'b10, 1, 4'd6, "t5");
        chk("t5.vip_up", 32'(tm.isvip), 32'(1));
        chk("t5.night_dn", 32'(tm.isnight), 32'(0));
        repeat (9) step(2'b10, 1, 4'd6, "t5");
        for (int i = 0; i < 20 && tm.isvip === 1'b1; i++) step(2'b00, 1, 4'd6, "t5");
        lows = 1;
        for (int i = 0; i < 20 && tm.isnight !== 1'b1; i++) begin
            step(2'b00, 1, 4'd6, "t5");
            if (tm.isnight !== 1'b1) lows++;
        end
        chk("t5.gap_lows", 32'(lows), 32'(GAP_CYC + 1));
        chk("t5.npath", 32'(tm.night_path_index), 32'(0));
        step(2'b00, 0, 4'd6, "t5");
        for (int i = 0; i < 20 && (m_gap > 0 || m_night); i++) step(2'b00, 0, 4'd0, "t5");

        // Asynchronous reset in the middle of a VIP session.
        for (int i = 0; i < 20 && m_age != 5; i++) step(2'b01, 0, 4'd11, "t6");
        chk("t6.age5", 32'(tm.isvip), 32'(1));
        start = 1'b0;
        #1;
        model_reset();
        check_outs("t6.async");
        tm.vip_req = 2'b00;
        @(negedge clk);
        start = 1'b1;
        repeat (6) step(2'b00, 0, 4'd0, "t6.idle");
        chk("t6.busy", 32'(tm.busy), 32'(0));

        // Random traffic against the model.
        r = 2'b00;
        n = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 9) == 0) r = 2'($urandom);
            if ($urandom_range(0, 39) == 0) n = ~n;
            step(r, n, 4'($urandom), "rnd");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
